branch_predictor_btb: RTL and testbench
=======================================

// Module: branch_predictor_btb
// PURPOSE
//  Dynamic branch predictor for the 5-stage RV32I pipeline; replaces the static not-taken/redirect-in-EX scheme.
//  Fetch looks up a direct-mapped BTB with 2-bit counters and gets a predicted next PC in the same cycle.
//  Execute reports each resolved control instruction; the block trains its tables and flags a mispredict.
//  It also supplies the redirect PC that the hazard unit uses to flush IF/ID and ID/EX.
// PARAMETERS
//  ENTRIES  64  BTB/BHT entry count, power of 2, minimum 4; IDX_W = $clog2(ENTRIES)
//  XLEN     32  PC and target width
//  TAG_W    8   stored tag bits, taken from pc[IDX_W+2 +: TAG_W]
//  GHR_W    6   global history length; used only with BP_GSHARE_EN; must be <= IDX_W
// PORTS
//  i_clk            in   1       clock, rising edge
//  i_reset          in   1       asynchronous reset, active-high
//  i_pc_fetch       in   XLEN    PC currently in fetch
//  o_pred_hit       out  1       valid BTB tag match for i_pc_fetch
//  o_pred_taken     out  1       predicted taken; equals hit & counter[1]
//  o_pred_pc        out  XLEN    predicted next PC: taken ? stored target : i_pc_fetch+4
//  o_pred_ghr       out  GHR_W   history used for this lookup; the pipeline carries it to EX (zero without macro)
//  i_upd_vld        in   1       EX holds a valid, non-flushed instruction this cycle
//  i_upd_is_ctrl    in   1       instruction is a branch or jump
//  i_upd_is_jump    in   1       instruction is JAL/JALR (always taken)
//  i_upd_pc         in   XLEN    PC of the resolving instruction
//  i_upd_taken      in   1       actual outcome
//  i_upd_target     in   XLEN    actual target (ALU result)
//  i_upd_pred_taken in   1       o_pred_taken carried from fetch
//  i_upd_pred_pc    in   XLEN    o_pred_pc carried from fetch
//  i_upd_ghr        in   GHR_W   o_pred_ghr carried from fetch
//  o_ctrl           out  1       i_upd_vld & i_upd_is_ctrl
//  o_mispred        out  1       the resolved next PC differs from i_upd_pred_pc
//  o_redirect_pc    out  XLEN    correct next PC: i_upd_taken ? i_upd_target : i_upd_pc+4
//  o_ctrl_cnt       out  32      count of o_ctrl cycles, wraps
//  o_mispred_cnt    out  32      count of o_mispred cycles, wraps
// BEHAVIOUR
//  - Lookup is purely combinational from i_pc_fetch (0 cycles). idx = pc[IDX_W+1:2]; tag = pc[IDX_W+2 +: TAG_W].
//  - Entry contents: valid, tag, target, 2-bit counter (SNT=00, WNT=01, WT=10, ST=11).
//  - Reset (async, any time including mid-update): all valid=0, counters=WNT, GHR=0, both perf counters=0.
//  - Reset output values: o_pred_hit=0, o_pred_taken=0, o_pred_pc=i_pc_fetch+4, o_ctrl=0, o_mispred=0, o_redirect_pc=0.
//  - Mispredict rule, when i_upd_vld & i_upd_is_ctrl:
//      o_mispred = (resolved next PC != i_upd_pred_pc).
//      A non-control instruction (is_ctrl=0) never reports a mispredict.
//  - Update happens at the posedge after i_upd_vld & i_upd_is_ctrl, at the update index:
//      hit & branch: counter saturates, +1 if taken, -1 if not taken; target <= i_upd_target if taken.
//      hit & jump: counter <= ST; target <= i_upd_target.
//      miss & taken: allocate (overwrite the entry); valid=1, tag, target; counter = ST for jump, WT for branch.
//      miss & not taken: no allocation, table unchanged.
//  - Saturation: ST+taken stays ST; SNT+not-taken stays SNT.
//  - Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no bypass).
//  - Perf counters: +1 on each o_ctrl / o_mispred cycle; XLEN-independent 32-bit; 0xFFFFFFFF wraps to 0.
// CONFIGURATION
//  BP_GSHARE_EN defined:
//      counter index = pc[IDX_W+1:2] ^ {0, GHR}; BTB valid/tag/target still use the plain pc index.
//      GHR is non-speculative. On each resolved branch (not jumps) GHR <= {i_upd_ghr[GHR_W-2:0], i_upd_taken}.
//      The update index uses i_upd_ghr.
//  BP_GSHARE_EN undefined:
//      no GHR flops; counter index = BTB index; o_pred_ghr=0; i_upd_ghr ignored.
// STRUCTURE
//  bp_pkg: typedef bp_cnt_e (SNT/WNT/WT/ST), typedef struct bp_btb_entry_t {valid, tag, target}.
//  bp_sat_counter: sub-module, 2-bit next-state function (cnt, taken -> cnt_nxt); instantiated once on the update path.
//  Tables are register arrays (no RAM macro), so the lookup can stay asynchronous.
// TESTING
//  1 Reset, then i_pc_fetch=0x100 -> o_pred_hit=0, o_pred_pc=0x104; assert reset mid-run -> both perf counters read 0.
//  2 Branch at 0x100 taken to 0x80, pred_pc=0x104 -> o_mispred=1, o_redirect_pc=0x80; next lookup of 0x100 -> hit, taken, pred_pc=0x80.
//  3 Same branch not taken 3 times -> counter WT->WNT->SNT->SNT; pred_pc=0x104; only the first resolve mispredicts.
//  4 JAL at 0x200 to 0x400 -> allocated at ST; 0x200+4*ENTRIES aliases the index with a different tag -> hit=0.
//  5 Update and lookup of the same index in one cycle -> lookup shows old contents; new contents visible next cycle.
//  6 BP_GSHARE_EN: T,N,T,N pattern at 0x300 -> after warm-up o_mispred stays 0; macro off -> mispredicts persist.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the BTB branch predictor: 2-bit counter encoding and BTB entry layout.
package bp_pkg;

  localparam int BP_XLEN  = 32;
  localparam int BP_TAG_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
  } bp_btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating 2-bit counter next-state function used when a branch resolves.
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_cnt_e cnt,
  input  logic    taken,
  output bp_cnt_e cnt_nxt
);

  // step toward the actual outcome, holding at either end
  always_comb begin
    cnt_nxt = cnt;
    case (cnt)
      SNT:     cnt_nxt = taken ? WNT : SNT;
      WNT:     cnt_nxt = taken ? WT  : SNT;
      WT:      cnt_nxt = taken ? ST  : WNT;
      ST:      cnt_nxt = taken ? ST  : WT;
      default: cnt_nxt = WNT;
    endcase
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: zero-cycle fetch lookup, training and mispredict flag from EX.
// Optional gshare counter indexing is enabled with the BP_GSHARE_EN macro.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = BP_XLEN,
  parameter int TAG_W   = BP_TAG_W,
  parameter int GHR_W   = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [XLEN-1:0]  i_pc_fetch,
  output logic             o_pred_hit,
  output logic             o_pred_taken,
  output logic [XLEN-1:0]  o_pred_pc,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_upd_vld,
  input  logic             i_upd_is_ctrl,
  input  logic             i_upd_is_jump,
  input  logic [XLEN-1:0]  i_upd_pc,
  input  logic             i_upd_taken,
  input  logic [XLEN-1:0]  i_upd_target,
  input  logic             i_upd_pred_taken,
  input  logic [XLEN-1:0]  i_upd_pred_pc,
  input  logic [GHR_W-1:0] i_upd_ghr,
  output logic             o_ctrl,
  output logic             o_mispred,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic [31:0]      o_ctrl_cnt,
  output logic [31:0]      o_mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  bp_btb_entry_t    btb_r [ENTRIES];
  bp_cnt_e          cnt_r [ENTRIES];
  logic [31:0]      ctrl_cnt_r;
  logic [31:0]      mispred_cnt_r;

  logic [IDX_W-1:0] f_idx_s, f_cidx_s, u_idx_s, u_cidx_s;
  logic [TAG_W-1:0] f_tag_s, u_tag_s;
  bp_btb_entry_t    f_ent_s, u_ent_s;
  logic             f_hit_s, u_hit_s, ctrl_s;
  logic [XLEN-1:0]  next_pc_s;
  bp_cnt_e          u_cnt_s, u_cnt_nxt_s;
  logic             unused_s;

  assign f_idx_s  = i_pc_fetch[IDX_W+1:2];
  assign f_tag_s  = i_pc_fetch[IDX_W+2 +: TAG_W];
  assign u_idx_s  = i_upd_pc[IDX_W+1:2];
  assign u_tag_s  = i_upd_pc[IDX_W+2 +: TAG_W];
  assign unused_s = &{1'b0, i_upd_pred_taken, i_upd_ghr};

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_r;

  assign f_cidx_s   = f_idx_s ^ IDX_W'(ghr_r);
  assign u_cidx_s   = u_idx_s ^ IDX_W'(i_upd_ghr);
  assign o_pred_ghr = ghr_r;

  // non-speculative history, rebuilt from the history carried with each resolved branch
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ghr_r <= {GHR_W{1'b0}};
    end else if (ctrl_s && !i_upd_is_jump) begin
      ghr_r <= {i_upd_ghr[GHR_W-2:0], i_upd_taken};
    end
  end
`else
  assign f_cidx_s   = f_idx_s;
  assign u_cidx_s   = u_idx_s;
  assign o_pred_ghr = {GHR_W{1'b0}};
`endif

  // fetch-side lookup, purely combinational from the table registers
  always_comb begin
    f_ent_s      = btb_r[f_idx_s];
    f_hit_s      = f_ent_s.valid && (f_ent_s.tag == f_tag_s);
    o_pred_hit   = f_hit_s;
    o_pred_taken = f_hit_s && cnt_r[f_cidx_s][1];
    if (o_pred_taken) begin
      o_pred_pc = f_ent_s.target;
    end else begin
      o_pred_pc = i_pc_fetch + PC_STEP;
    end
  end

  // EX-side resolution; outputs forced quiet while reset is asserted
  always_comb begin
    ctrl_s    = i_upd_vld && i_upd_is_ctrl;
    u_ent_s   = btb_r[u_idx_s];
    u_hit_s   = u_ent_s.valid && (u_ent_s.tag == u_tag_s);
    u_cnt_s   = cnt_r[u_cidx_s];
    next_pc_s = i_upd_taken ? i_upd_target : (i_upd_pc + PC_STEP);
    if (i_reset) begin
      o_ctrl        = 1'b0;
      o_mispred     = 1'b0;
      o_redirect_pc = {XLEN{1'b0}};
    end else begin
      o_ctrl        = ctrl_s;
      o_mispred     = ctrl_s && (next_pc_s != i_upd_pred_pc);
      o_redirect_pc = next_pc_s;
    end
  end

  bp_sat_counter u_sat (
    .cnt     (u_cnt_s),
    .taken   (i_upd_taken),
    .cnt_nxt (u_cnt_nxt_s)
  );

  // table training: counters always, BTB target/allocation only on taken outcomes
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_r[i] <= {$bits(bp_btb_entry_t){1'b0}};
        cnt_r[i] <= WNT;
      end
    end else if (ctrl_s) begin
      if (u_hit_s) begin
        if (i_upd_is_jump) begin
          cnt_r[u_cidx_s]        <= ST;
          btb_r[u_idx_s].target <= i_upd_target;
        end else begin
          cnt_r[u_cidx_s] <= u_cnt_nxt_s;
          if (i_upd_taken) begin
            btb_r[u_idx_s].target <= i_upd_target;
          end
        end
      end else if (i_upd_taken) begin
        btb_r[u_idx_s]  <= '{valid: 1'b1, tag: u_tag_s, target: i_upd_target};
        cnt_r[u_cidx_s] <= i_upd_is_jump ? ST : WT;
      end
    end
  end

  // wrapping performance counters
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_cnt_r    <= 32'd0;
      mispred_cnt_r <= 32'd0;
    end else begin
      if (o_ctrl) begin
        ctrl_cnt_r <= ctrl_cnt_r + 32'd1;
      end
      if (o_mispred) begin
        mispred_cnt_r <= mispred_cnt_r + 32'd1;
      end
    end
  end

  assign o_ctrl_cnt    = ctrl_cnt_r;
  assign o_mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb (default build and BP_GSHARE_EN build).
module tb_branch_predictor_btb;

  logic        i_clk;
  logic        i_reset;
  logic [31:0] i_pc_fetch;
  logic        o_pred_hit;
  logic        o_pred_taken;
  logic [31:0] o_pred_pc;
  logic [5:0]  o_pred_ghr;
  logic        i_upd_vld;
  logic        i_upd_is_ctrl;
  logic        i_upd_is_jump;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_pc;
  logic [5:0]  i_upd_ghr;
  logic        o_ctrl;
  logic        o_mispred;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_ctrl_cnt;
  logic [31:0] o_mispred_cnt;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_mis6;

  branch_predictor_btb dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_pc_fetch       (i_pc_fetch),
    .o_pred_hit       (o_pred_hit),
    .o_pred_taken     (o_pred_taken),
    .o_pred_pc        (o_pred_pc),
    .o_pred_ghr       (o_pred_ghr),
    .i_upd_vld        (i_upd_vld),
    .i_upd_is_ctrl    (i_upd_is_ctrl),
    .i_upd_is_jump    (i_upd_is_jump),
    .i_upd_pc         (i_upd_pc),
    .i_upd_taken      (i_upd_taken),
    .i_upd_target     (i_upd_target),
    .i_upd_pred_taken (i_upd_pred_taken),
    .i_upd_pred_pc    (i_upd_pred_pc),
    .i_upd_ghr        (i_upd_ghr),
    .o_ctrl           (o_ctrl),
    .o_mispred        (o_mispred),
    .o_redirect_pc    (o_redirect_pc),
    .o_ctrl_cnt       (o_ctrl_cnt),
    .o_mispred_cnt    (o_mispred_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tkn, input logic [31:0] ppc);
    i_pc_fetch = pc;
    #1;
    check({tag, "_hit"}, {31'd0, o_pred_hit}, {31'd0, hit});
    check({tag, "_taken"}, {31'd0, o_pred_taken}, {31'd0, tkn});
    check({tag, "_pc"}, o_pred_pc, ppc);
  endtask

  // fetch lookup supplies the carried prediction, then EX resolves it for one cycle
  task automatic resolve(input string tag, input logic [31:0] pc, input logic taken,
                         input logic jump, input logic [31:0] target,
                         input logic exp_mis, input logic [31:0] exp_redir);
    i_pc_fetch = pc;
    #1;
    i_upd_vld        = 1'b1;
    i_upd_is_ctrl    = 1'b1;
    i_upd_is_jump    = jump;
    i_upd_pc         = pc;
    i_upd_taken      = taken;
    i_upd_target     = target;
    i_upd_pred_taken = o_pred_taken;
    i_upd_pred_pc    = o_pred_pc;
    i_upd_ghr        = o_pred_ghr;
    #1;
    check({tag, "_mispred"}, {31'd0, o_mispred}, {31'd0, exp_mis});
    check({tag, "_redirect"}, o_redirect_pc, exp_redir);
    @(posedge i_clk);
    #1;
    i_upd_vld     = 1'b0;
    i_upd_is_ctrl = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_pc_fetch = 32'h100;
    i_upd_vld = 1'b1; i_upd_is_ctrl = 1'b1; i_upd_is_jump = 1'b0;
    i_upd_pc = 32'h100; i_upd_taken = 1'b1; i_upd_target = 32'h80;
    i_upd_pred_taken = 1'b0; i_upd_pred_pc = 32'h104; i_upd_ghr = 6'd0;
`ifdef BP_GSHARE_EN
    exp_mis6 = 10'b00_0101_0101;
`else
    exp_mis6 = 10'b11_1111_1111;
`endif
    #12;
    // 1: reset state
    lookup("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    check("rst_ctrl", {31'd0, o_ctrl}, 32'd0);
    check("rst_mispred", {31'd0, o_mispred}, 32'd0);
    check("rst_redirect", o_redirect_pc, 32'd0);
    check("rst_ghr", {26'd0, o_pred_ghr}, 32'd0);
    check("rst_ctrl_cnt", o_ctrl_cnt, 32'd0);
    check("rst_mis_cnt", o_mispred_cnt, 32'd0);
    i_reset = 1'b0; i_upd_vld = 1'b0;
    @(posedge i_clk); #1;

    // non-control instruction: no mispredict, no training
    i_upd_vld = 1'b1; i_upd_is_ctrl = 1'b0; i_upd_taken = 1'b1; i_upd_target = 32'h80;
    i_upd_pred_pc = 32'h104;
    #1;
    check("nonctrl_mispred", {31'd0, o_mispred}, 32'd0);
    check("nonctrl_ctrl", {31'd0, o_ctrl}, 32'd0);
    @(posedge i_clk); #1;
    i_upd_vld = 1'b0;
    lookup("nonctrl_tbl", 32'h100, 1'b0, 1'b0, 32'h104);
    check("nonctrl_cnt", o_ctrl_cnt, 32'd0);

`ifndef BP_GSHARE_EN
    // 2: first taken branch allocates at WT
    resolve("t2", 32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    lookup("t2_look", 32'h100, 1'b1, 1'b1, 32'h80);
    // 3: not taken three times, WT->WNT->SNT->SNT
    resolve("t3a", 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h104);
    resolve("t3b", 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    resolve("t3c", 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    lookup("t3_look", 32'h100, 1'b1, 1'b0, 32'h104);
    // 4: JAL allocates at ST; 0x300 aliases index 0 with another tag
    resolve("t4", 32'h200, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400);
    lookup("t4_look", 32'h200, 1'b1, 1'b1, 32'h400);
    lookup("t4_alias", 32'h300, 1'b0, 1'b0, 32'h304);
    // 5: same-index lookup and update in one cycle sees old contents
    i_pc_fetch = 32'h200;
    i_upd_vld = 1'b1; i_upd_is_ctrl = 1'b1; i_upd_is_jump = 1'b0; i_upd_pc = 32'h300;
    i_upd_taken = 1'b1; i_upd_target = 32'h500; i_upd_pred_taken = 1'b0; i_upd_pred_pc = 32'h304;
    #1;
    check("t5_old_hit", {31'd0, o_pred_hit}, 32'd1);
    check("t5_old_pc", o_pred_pc, 32'h400);
    check("t5_mispred", {31'd0, o_mispred}, 32'd1);
    @(posedge i_clk); #1;
    i_upd_vld = 1'b0; i_upd_is_ctrl = 1'b0;
    lookup("t5_new_old", 32'h200, 1'b0, 1'b0, 32'h204);
    lookup("t5_new", 32'h300, 1'b1, 1'b1, 32'h500);
    check("t5_ctrl_cnt", o_ctrl_cnt, 32'd6);
    check("t5_mis_cnt", o_mispred_cnt, 32'd4);
`endif

    // asynchronous reset in the middle of an update cycle
    i_upd_vld = 1'b1; i_upd_is_ctrl = 1'b1; i_upd_pc = 32'h300; i_upd_taken = 1'b1;
    i_upd_target = 32'h600; i_upd_pred_pc = 32'h304;
    #3;
    i_reset = 1'b1;
    #1;
    check("mid_rst_ctrl_cnt", o_ctrl_cnt, 32'd0);
    check("mid_rst_mis_cnt", o_mispred_cnt, 32'd0);
    check("mid_rst_mispred", {31'd0, o_mispred}, 32'd0);
    lookup("mid_rst", 32'h300, 1'b0, 1'b0, 32'h304);
    i_upd_vld = 1'b0; i_upd_is_ctrl = 1'b0;
    @(posedge i_clk); #2;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    lookup("post_rst", 32'h300, 1'b0, 1'b0, 32'h304);

    // 6: alternating T,N at 0x300 from a clean table
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        resolve($sformatf("t6_%0d", k), 32'h300, 1'b1, 1'b0, 32'h500, exp_mis6[k], 32'h500);
      end else begin
        resolve($sformatf("t6_%0d", k), 32'h300, 1'b0, 1'b0, 32'h500, exp_mis6[k], 32'h304);
      end
    end
    check("t6_ctrl_cnt", o_ctrl_cnt, 32'd10);
`ifdef BP_GSHARE_EN
    check("t6_mis_cnt", o_mispred_cnt, 32'd4);
`else
    check("t6_mis_cnt", o_mispred_cnt, 32'd10);
    lookup("t6_look", 32'h300, 1'b1, 1'b0, 32'h304);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
